axis_sink_checker: RTL
======================

Name: axis_sink_checker

Overview:
- AXI-Stream receiver-end checker that terminates a stream, e.g. the m_axis side of axis_fifo.
- Drives tready using a pseudo-random backpressure pattern.
- Checks each accepted beat against an expected incrementing sequence.
- Monitors source protocol (data stability, no valid withdrawal) and detects hangs via a timeout.
- Synthesizable companion for benches and on-chip loopback self-test.

Parameters:
- DATA_WIDTH, 32, tdata width in bits.
- START_VALUE, 0, expected value of the first beat after reset/clear.
- READY_THRESH, 0, 0..16; tready offered when lfsr[3:0] >= READY_THRESH (0 = always ready, 16 = never).
- LFSR_SEED, 16'hACE1, backpressure LFSR reset value; must be nonzero.
- MAX_WAIT, 1024, consecutive no-tvalid cycles in RUN that declare a hang.
- CNT_WIDTH, 32, width of beat and error counters.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- enable  in  1  level; start/continue checking.
- clear  in  1  synchronous pulse; return to IDLE and zero all status.
- s_axis_tdata  in  DATA_WIDTH  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  registered ready.
- beat_count  out  CNT_WIDTH  accepted beats.
- err_count  out  CNT_WIDTH  data-mismatch beats.
- err_actual  out  DATA_WIDTH  tdata of first mismatch.
- err_expected  out  DATA_WIDTH  expected value at first mismatch.
- data_err  out  1  sticky; a mismatch has occurred.
- proto_err  out  1  sticky; protocol violation seen.
- hang  out  1  sticky; timeout fired.

Behaviour:
- Reset: state=IDLE; tready=0; counters, err_actual, err_expected, data_err, proto_err, hang=0; expected=START_VALUE; lfsr=LFSR_SEED; wait_cnt=0.
- Handshake: beat accepted on a rising edge with s_axis_tvalid && s_axis_tready. No combinational path from input to output.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; shift left, feedback into bit 0. Advances every cycle in RUN only.
- FSM IDLE: tready=0. enable=1 -> RUN next cycle.
- FSM RUN: tready_next = enable && (lfsr_next[3:0] >= READY_THRESH).
  - enable=0 -> IDLE. tready drops next cycle; counters and expected are held.
  - wait_cnt reaching MAX_WAIT-1 with no tvalid -> HANG.
- FSM HANG: tready=0; hang=1. Only clear or areset leaves it.
- On each accepted beat:
  - beat_count +1, saturating at all-ones.
  - If tdata != expected: err_count +1 (saturating). On the first mismatch only, capture err_actual/err_expected and set data_err.
  - expected +1 mod 2^DATA_WIDTH whether or not the beat mismatched, so the checker resyncs to the index, not the data.
- wait_cnt (RUN only): cleared on any cycle with tvalid=1; otherwise increments.
- Protocol monitor, active in RUN and HANG. Registers prev_valid, prev_ready, prev_data. Sets proto_err if prev_valid && !prev_ready and either:
  - tvalid=0 (valid withdrawn), or
  - tdata != prev_data (data changed while stalled).
- clear has priority over every event except areset. Takes effect next edge: all outputs return to reset values, state=IDLE, lfsr=LFSR_SEED.
- clear and a handshake in the same cycle: the beat is discarded, not counted.
- areset mid-beat: immediate return to reset values; no partial update.
- Wrap: expected rolls all-ones -> 0 with no error.

Test Plan:
- READY_THRESH=0, START_VALUE=0; source sends 0..99 back-to-back -> tready high from the 2nd cycle after enable; beat_count=100; err_count=0; no sticky flags.
- Source sends 0,1,2,7,4 -> err_count=1; err_actual=7; err_expected=3; data_err=1; beat_count=5; a later mismatch leaves err_actual unchanged.
- READY_THRESH=8, 500-beat correct stream with source holding valid/data while stalled -> tready duty roughly 50%; beat_count=500; proto_err=0.
- Source deasserts tvalid while tready=0, then separately changes tdata while stalled -> proto_err=1 after the first event; stays set.
- enable=1, no tvalid for MAX_WAIT=16 cycles -> hang=1 and tready=0 at cycle 16; pulse clear -> all outputs 0, state IDLE.
- DATA_WIDTH=8, START_VALUE=8'hFE, stream FE,FF,00,01 -> err_count=0; areset asserted mid-stream -> outputs zero without waiting for a clock edge.

Source files
------------

// File: rtl/axis_sink_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : axis_sink_checker
// Brief  : AXI-Stream sink with LFSR backpressure, incrementing-data checker,
//          source protocol monitor and no-traffic hang timeout.
// Rev    : 1.0 - initial release
// ============================================================================

module axis_sink_checker #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] START_VALUE  = '0,
    parameter int                    READY_THRESH = 0,
    parameter logic [15:0]           LFSR_SEED    = 16'hACE1,
    parameter int                    MAX_WAIT     = 1024,
    parameter int                    CNT_WIDTH    = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [DATA_WIDTH-1:0] err_actual,
    output logic [DATA_WIDTH-1:0] err_expected,
    output logic                  data_err,
    output logic                  proto_err,
    output logic                  hang
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HANG = 2'd2
    } state_t;

    localparam int                    c_WAIT_W       = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST    = c_WAIT_W'(MAX_WAIT - 1);
    localparam logic [4:0]            c_READY_THRESH = 5'(READY_THRESH);

    state_t                r_state;
    state_t                w_state_next;
    logic [15:0]           r_lfsr;
    logic [15:0]           w_lfsr_next;
    logic [c_WAIT_W-1:0]   r_wait_cnt;
    logic [DATA_WIDTH-1:0] r_expected;
    logic [DATA_WIDTH-1:0] r_prev_data;
    logic                  r_prev_valid;
    logic                  r_prev_ready;
    logic                  w_tready_next;
    logic                  w_hang_set;
    logic                  w_beat;
    logic                  w_mismatch;
    logic                  w_proto_viol;

    // Fibonacci taps 16,14,13,11 shifted left with feedback into bit 0
    assign w_lfsr_next  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_beat       = s_axis_tvalid && s_axis_tready;
    assign w_mismatch   = (s_axis_tdata != r_expected);
    assign w_proto_viol = (r_state != S_IDLE) && r_prev_valid && !r_prev_ready &&
                          (!s_axis_tvalid || (s_axis_tdata != r_prev_data));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_tready_next = 1'b0;
        w_hang_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    w_state_next = S_IDLE;
                end else if (!s_axis_tvalid && (r_wait_cnt == c_WAIT_LAST)) begin
                    w_state_next = S_HANG;
                    w_hang_set   = 1'b1;
                end else begin
                    w_tready_next = ({1'b0, w_lfsr_next[3:0]} >= c_READY_THRESH);
                end
            end
            S_HANG: begin
                w_state_next = S_HANG;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (clear) begin
            w_state_next  = S_IDLE;
            w_tready_next = 1'b0;
            w_hang_set    = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s_axis_tready <= 1'b0;
            beat_count    <= '0;
            err_count     <= '0;
            err_actual    <= '0;
            err_expected  <= '0;
            data_err      <= 1'b0;
            proto_err     <= 1'b0;
            hang          <= 1'b0;
            r_expected    <= START_VALUE;
            r_lfsr        <= LFSR_SEED;
            r_wait_cnt    <= '0;
            r_prev_valid  <= 1'b0;
            r_prev_ready  <= 1'b0;
            r_prev_data   <= '0;
        end else if (clear) begin
            s_axis_tready <= 1'b0;
            beat_count    <= '0;
            err_count     <= '0;
            err_actual    <= '0;
            err_expected  <= '0;
            data_err      <= 1'b0;
            proto_err     <= 1'b0;
            hang          <= 1'b0;
            r_expected    <= START_VALUE;
            r_lfsr        <= LFSR_SEED;
            r_wait_cnt    <= '0;
            r_prev_valid  <= 1'b0;
            r_prev_ready  <= 1'b0;
            r_prev_data   <= '0;
        end else begin
            s_axis_tready <= w_tready_next;
            hang          <= hang | w_hang_set;
            r_prev_valid  <= s_axis_tvalid;
            r_prev_ready  <= s_axis_tready;
            r_prev_data   <= s_axis_tdata;

            if (w_proto_viol) begin
                proto_err <= 1'b1;
            end

            // Timeout counter saturates so a pause at the limit cannot wrap it
            if (r_state == S_RUN) begin
                r_lfsr <= w_lfsr_next;
                if (s_axis_tvalid) begin
                    r_wait_cnt <= '0;
                end else if (r_wait_cnt != c_WAIT_LAST) begin
                    r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                end
            end

            // Expected tracks the beat index so one bad beat costs one error
            if (w_beat) begin
                r_expected <= r_expected + DATA_WIDTH'(1);
                if (beat_count != '1) begin
                    beat_count <= beat_count + CNT_WIDTH'(1);
                end
                if (w_mismatch) begin
                    if (err_count != '1) begin
                        err_count <= err_count + CNT_WIDTH'(1);
                    end
                    if (!data_err) begin
                        data_err     <= 1'b1;
                        err_actual   <= s_axis_tdata;
                        err_expected <= r_expected;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
